// File: rtl/ft8_tone_sequencer_if.sv
// Bundle between the packed-message encoder (master) and the FT8 tone sequencer (slave).
// Handshake: packed_msg_valid is a one-cycle strobe, never held; it is taken only while ready is high,
// otherwise the message is dropped and overrun pulses one cycle later. Tone outputs need no ready.
interface ft8_tone_sequencer_if;
    logic [86:0] packed_msg;
    logic        packed_msg_valid;
    logic        abort;
    logic        ready;
    logic [2:0]  tone;
    logic        tone_valid;
    logic        sym_start;
    logic [5:0]  sym_idx;
    logic        frame_done;
    logic        overrun;

    modport master (
        output packed_msg, packed_msg_valid, abort,
        input  ready, tone, tone_valid, sym_start, sym_idx, frame_done, overrun
    );

    modport slave (
        input  packed_msg, packed_msg_valid, abort,
        output ready, tone, tone_valid, sym_start, sym_idx, frame_done, overrun
    );
endinterface

// File: rtl/ft8_tone_sequencer.sv
// FT8 tone sequencer: 87-bit packed message -> 51-symbol Costas/data tone frame, SYM_CYCLES clocks per tone.
// Macro FT8_TONE_GRAY_MAP_EN selects Gray-mapped data tones; undefined gives the binary identity map.
module ft8_tone_sequencer #(
    parameter int SYM_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ft8_tone_sequencer_if.slave   bus,
    output logic                  dbg_run
);

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    localparam logic [15:0] CNT_MAX  = 16'(SYM_CYCLES - 1);
    localparam logic [5:0]  LAST_SYM = 6'd50;

    state_t      state_q, state_d;
    logic [89:0] padded_q, padded_d;
    logic [15:0] cnt_q, cnt_d;
    logic [5:0]  sym_q, sym_d;
    logic [2:0]  tone_q, tone_d;
    logic        tone_valid_q, tone_valid_d;
    logic        sym_start_q, sym_start_d;
    logic        frame_done_q, frame_done_d;
    logic        overrun_q, overrun_d;

    // Tone for frame position pos: Costas blocks at 0, 22, 44; data blocks of 15 in between.
    function automatic logic [2:0] sym_tone(input logic [5:0] pos, input logic [89:0] pad);
        logic       is_sync;
        logic [5:0] off;
        logic [6:0] hi;
        logic [2:0] raw;
        logic [2:0] res;
        is_sync = 1'b0;
        off     = 6'd0;
        if (pos < 6'd7) begin
            is_sync = 1'b1;
            off     = pos;
        end else if (pos < 6'd22) begin
            off = pos - 6'd7;
        end else if (pos < 6'd29) begin
            is_sync = 1'b1;
            off     = pos - 6'd22;
        end else if (pos < 6'd44) begin
            off = pos - 6'd14;
        end else begin
            is_sync = 1'b1;
            off     = pos - 6'd44;
        end
        hi  = 7'd89 - ({1'b0, off} * 7'd3);
        raw = pad[hi -: 3];
        res = 3'd0;
        if (is_sync) begin
            case (off[2:0])
                3'd0:    res = 3'd3;
                3'd1:    res = 3'd1;
                3'd2:    res = 3'd4;
                3'd3:    res = 3'd0;
                3'd4:    res = 3'd6;
                3'd5:    res = 3'd5;
                3'd6:    res = 3'd2;
                default: res = 3'd0;
            endcase
        end else begin
`ifdef FT8_TONE_GRAY_MAP_EN
            case (raw)
                3'd0:    res = 3'd0;
                3'd1:    res = 3'd1;
                3'd2:    res = 3'd3;
                3'd3:    res = 3'd2;
                3'd4:    res = 3'd6;
                3'd5:    res = 3'd7;
                3'd6:    res = 3'd5;
                default: res = 3'd4;
            endcase
`else
            res = raw;
`endif
        end
        return res;
    endfunction

    always_comb begin
        state_d      = state_q;
        padded_d     = padded_q;
        cnt_d        = cnt_q;
        sym_d        = sym_q;
        tone_d       = tone_q;
        tone_valid_d = tone_valid_q;
        sym_start_d  = 1'b0;
        frame_done_d = 1'b0;
        overrun_d    = 1'b0;
        if (state_q == ST_IDLE) begin
            if (bus.packed_msg_valid) begin
                state_d      = ST_RUN;
                padded_d     = {bus.packed_msg, 3'b000};
                cnt_d        = 16'd0;
                sym_d        = 6'd0;
                tone_d       = sym_tone(6'd0, {bus.packed_msg, 3'b000});
                tone_valid_d = 1'b1;
                sym_start_d  = 1'b1;
            end
        end else begin
            // A strobe while running is always dropped, even when abort wins the same cycle.
            overrun_d = bus.packed_msg_valid;
            if (bus.abort) begin
                state_d      = ST_IDLE;
                cnt_d        = 16'd0;
                sym_d        = 6'd0;
                tone_d       = 3'd0;
                tone_valid_d = 1'b0;
            end else if (cnt_q == CNT_MAX) begin
                cnt_d = 16'd0;
                if (sym_q == LAST_SYM) begin
                    state_d      = ST_IDLE;
                    sym_d        = 6'd0;
                    tone_d       = 3'd0;
                    tone_valid_d = 1'b0;
                    frame_done_d = 1'b1;
                end else begin
                    sym_d       = sym_q + 6'd1;
                    tone_d      = sym_tone(sym_q + 6'd1, padded_q);
                    sym_start_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            padded_q     <= '0;
            cnt_q        <= '0;
            sym_q        <= '0;
            tone_q       <= '0;
            tone_valid_q <= 1'b0;
            sym_start_q  <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            padded_q     <= padded_d;
            cnt_q        <= cnt_d;
            sym_q        <= sym_d;
            tone_q       <= tone_d;
            tone_valid_q <= tone_valid_d;
            sym_start_q  <= sym_start_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
        end
    end

    assign bus.ready      = (state_q == ST_IDLE);
    assign bus.tone       = tone_q;
    assign bus.tone_valid = tone_valid_q;
    assign bus.sym_start  = sym_start_q;
    assign bus.sym_idx    = sym_q;
    assign bus.frame_done = frame_done_q;
    assign bus.overrun    = overrun_q;
    assign dbg_run        = (state_q == ST_RUN);

endmodule

// File: tb/tb_ft8_tone_sequencer.sv
// Bench for ft8_tone_sequencer: random and directed frames against a frame-level reference model.
module tb_ft8_tone_sequencer;
    localparam int SC = 4;

    logic clk;
    logic rst_n;
    logic dbg_run0;
    logic dbg_run1;

    ft8_tone_sequencer_if bus ();
    ft8_tone_sequencer_if bus1 ();

    ft8_tone_sequencer #(.SYM_CYCLES(SC)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .dbg_run(dbg_run0)
    );
    ft8_tone_sequencer #(.SYM_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .dbg_run(dbg_run1)
    );

    // clock / reset / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // reference model: expected tones of a frame, in order
    logic [2:0] exp_q[$];
    int costas_lut[7] = '{3, 1, 4, 0, 6, 5, 2};
`ifdef FT8_TONE_GRAY_MAP_EN
    int data_lut[8] = '{0, 1, 3, 2, 6, 7, 5, 4};
`else
    int data_lut[8] = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif

    function automatic void model_frame(input logic [86:0] msg);
        logic [89:0] pad;
        logic [89:0] sh;
        int data[30];
        pad = {msg, 3'b000};
        for (int k = 0; k < 30; k++) begin
            sh = pad >> (87 - 3 * k);
            data[k] = data_lut[sh[2:0]];
        end
        exp_q.delete();
        for (int blk = 0; blk < 3; blk++) begin
            for (int j = 0; j < 7; j++) exp_q.push_back(3'(costas_lut[j]));
            if (blk < 2)
                for (int j = 0; j < 15; j++) exp_q.push_back(3'(data[blk * 15 + j]));
        end
    endfunction

    function automatic logic [86:0] rand_msg();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[86:0];
    endfunction

    // drivers
    logic [2:0] got_tones[51];

    task automatic start_msg(input logic [86:0] msg);
        @(negedge clk);
        bus.packed_msg       = msg;
        bus.packed_msg_valid = 1'b1;
        @(negedge clk);
        bus.packed_msg_valid = 1'b0;
    endtask

    task automatic wait_sym(input int idx);
        int ok;
        ok = 0;
        for (int i = 0; i < 400 && ok == 0; i++) begin
            if (bus.tone_valid && bus.sym_start && bus.sym_idx == 6'(idx)) ok = 1;
            else @(negedge clk);
        end
        check("wait_sym", ok, 1);
    endtask

    // Plays one frame and scores it; returns in the frame_done cycle. b2b strobes in the current cycle.
    task automatic run_frame(input logic [86:0] msg, input int ovr_sym, input bit b2b);
        int cyc, starts, vcyc, done, done_at, hold_bad, ready_bad, ovr_spur, ovr_pend;
        logic [2:0] cur;
        model_frame(msg);
        if (!b2b) @(negedge clk);
        bus.packed_msg       = msg;
        bus.packed_msg_valid = 1'b1;
        @(negedge clk);
        bus.packed_msg_valid = 1'b0;
        check("accept_tone", bus.tone, 3);
        check("accept_valid", bus.tone_valid, 1);
        check("accept_idx", bus.sym_idx, 0);
        check("accept_ready", bus.ready, 0);
        cyc = 0; starts = 0; vcyc = 0; done = 0; done_at = -1;
        hold_bad = 0; ready_bad = 0; ovr_spur = 0; ovr_pend = 0; cur = 3'd0;
        while (done == 0 && cyc <= 51 * SC + 4) begin
            if (ovr_pend != 0) begin
                bus.packed_msg_valid = 1'b0;
                check("overrun_pulse", bus.overrun, 1);
                ovr_pend = 0;
            end else if (bus.overrun) ovr_spur++;
            if (bus.tone_valid) begin
                vcyc++;
                if (bus.ready) ready_bad++;
                if (bus.sym_start) begin
                    if (cyc != starts * SC) hold_bad++;
                    if (starts < 51) got_tones[starts] = bus.tone;
                    check("sym_idx", bus.sym_idx, starts);
                    if (exp_q.size() > 0) check("tone", bus.tone, exp_q.pop_front());
                    else check("tone_extra", starts, 50);
                    cur = bus.tone;
                    starts++;
                    if (ovr_sym >= 0 && bus.sym_idx == 6'(ovr_sym)) begin
                        bus.packed_msg       = rand_msg();
                        bus.packed_msg_valid = 1'b1;
                        ovr_pend = 1;
                    end
                end else if (bus.tone != cur) hold_bad++;
            end
            if (bus.frame_done) begin
                done    = 1;
                done_at = cyc;
                check("done_ready", bus.ready, 1);
                check("done_valid", bus.tone_valid, 0);
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        check("frame_done_seen", done, 1);
        check("frame_done_at", done_at, 51 * SC);
        check("valid_cycles", vcyc, 51 * SC);
        check("sym_starts", starts, 51);
        check("hold_timing", hold_bad, 0);
        check("ready_low_in_frame", ready_bad, 0);
        check("spurious_overrun", ovr_spur, 0);
    endtask

    task automatic count_done(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.frame_done) n++;
        end
    endtask

    initial begin
        logic [86:0] m;
        int n, bad1;
        rst_n = 1'b0;
        bus.packed_msg = '0;  bus.packed_msg_valid = 1'b0;  bus.abort = 1'b0;
        bus1.packed_msg = '0; bus1.packed_msg_valid = 1'b0; bus1.abort = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", bus.ready, 1);
        check("rst_tone", bus.tone, 0);
        check("rst_valid", bus.tone_valid, 0);
        check("rst_sym_start", bus.sym_start, 0);
        check("rst_sym_idx", bus.sym_idx, 0);
        check("rst_done", bus.frame_done, 0);
        check("rst_overrun", bus.overrun, 0);
        check("rst_dbg", dbg_run0, 0);
        rst_n = 1'b1;

        // all-zero payload
        run_frame('0, -1, 1'b0);
        // bit mapping
        m = '0;
        m[86:84] = 3'b011;
        m[2:0]   = 3'b101;
        run_frame(m, -1, 1'b0);
`ifdef FT8_TONE_GRAY_MAP_EN
        check("map_sym7", got_tones[7], 2);
        check("map_sym42", got_tones[42], 7);
`else
        check("map_sym7", got_tones[7], 3);
        check("map_sym42", got_tones[42], 5);
`endif
        check("map_sym43", got_tones[43], 0);

        // random frames, then back-to-back
        for (int i = 0; i < 3; i++) run_frame(rand_msg(), -1, 1'b0);
        run_frame(rand_msg(), -1, 1'b1);

        // overrun at sym_idx 10
        run_frame(rand_msg(), 10, 1'b0);

        // abort at sym_idx 25, then restart
        start_msg(rand_msg());
        wait_sym(25);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort_valid", bus.tone_valid, 0);
        check("abort_tone", bus.tone, 0);
        check("abort_ready", bus.ready, 1);
        check("abort_done", bus.frame_done, 0);
        count_done(60, n);
        check("abort_no_done", n, 0);
        run_frame(rand_msg(), -1, 1'b0);

        // abort and strobe in the same running cycle
        start_msg(rand_msg());
        wait_sym(5);
        bus.abort = 1'b1;
        bus.packed_msg = rand_msg();
        bus.packed_msg_valid = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        bus.packed_msg_valid = 1'b0;
        check("abort_ovr_pulse", bus.overrun, 1);
        check("abort_ovr_ready", bus.ready, 1);
        check("abort_ovr_valid", bus.tone_valid, 0);
        @(negedge clk);
        check("abort_ovr_not_taken", bus.tone_valid, 0);
        check("abort_ovr_idle", bus.ready, 1);

        // reset mid-frame at sym_idx 30
        start_msg(rand_msg());
        wait_sym(30);
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_ready", bus.ready, 1);
        check("mrst_tone", bus.tone, 0);
        check("mrst_valid", bus.tone_valid, 0);
        check("mrst_sym_start", bus.sym_start, 0);
        check("mrst_sym_idx", bus.sym_idx, 0);
        check("mrst_done", bus.frame_done, 0);
        check("mrst_overrun", bus.overrun, 0);
        @(negedge clk);
        rst_n = 1'b1;
        count_done(60, n);
        check("mrst_no_done", n, 0);
        check("mrst_idle", bus.ready, 1);

        // SYM_CYCLES = 1 instance
        m = rand_msg();
        model_frame(m);
        @(negedge clk);
        bus1.packed_msg = m;
        bus1.packed_msg_valid = 1'b1;
        @(negedge clk);
        bus1.packed_msg_valid = 1'b0;
        bad1 = 0;
        for (int i = 0; i < 51; i++) begin
            if (!(bus1.tone_valid && bus1.sym_start && bus1.sym_idx == 6'(i))) bad1++;
            if (bus1.tone != exp_q.pop_front()) bad1++;
            @(negedge clk);
        end
        check("sc1_frame", bad1, 0);
        check("sc1_done", bus1.frame_done, 1);
        check("sc1_end_valid", bus1.tone_valid, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
